bus_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction-fetch (IF) requester and the data-memory (MEM) requester of the 5-stage core.
- Sequences one bus transaction at a time and returns results to the requester that owns the bus.
- Raises per-requester stall requests toward the pipeline stall controller while a requester waits.
- Handles IF flush, bus timeout and IF starvation.

---
 rtl/bus_arbiter_if.sv | 23 ++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - single-port memory bus command/response bundle
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W/8-1:0]   bus_wstrb_o;
    logic                  bus_ready_i;
    logic [DATA_W-1:0]     bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_ready_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_ready_i, bus_rdata_i
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - IF/MEM arbiter for a shared single-port memory bus
module bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_BURST_MAX = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_done_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic                mem_done_o,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_err_o,
    bus_arbiter_if.master       bus,
    output logic                stallreq_if_o,
    output logic                stallreq_mem_o
);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int STRK_W = $clog2(MEM_BURST_MAX + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MEM_BURST_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t              state, state_nxt;
    logic [TCNT_W-1:0]   tcnt;
    logic [STRK_W-1:0]   streak;
    logic                discard;
    logic                if_elig;
    logic                grant_if, grant_mem;
    logic                busy, ready_evt, tout_evt, complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
        if_elig     = if_req_i & ~if_flush_i;
        busy        = (state != IDLE);
        ready_evt   = busy & bus.bus_ready_i;
        // Ready takes priority over a timeout landing in the same cycle.
        tout_evt    = busy & ~bus.bus_ready_i & (tcnt == TCNT_LAST);
        complete    = ready_evt | tout_evt;
        if_done_o   = 1'b0;
        if_rdata_o  = '0;
        if_err_o    = 1'b0;
        mem_done_o  = 1'b0;
        mem_rdata_o = '0;
        mem_err_o   = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req_i && !(if_elig && streak == STRK_MAX)) begin
                    grant_mem = 1'b1;
                    state_nxt = BUSY_MEM;
                end else if (if_elig) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (complete) state_nxt = IDLE;
                // A flushed fetch still occupies the bus but its result is dropped.
                if (complete && !discard && !if_flush_i) begin
                    if_done_o  = 1'b1;
                    if_err_o   = tout_evt;
                    if_rdata_o = ready_evt ? bus.bus_rdata_i : '0;
                end
            end
            BUSY_MEM: begin
                if (complete) begin
                    state_nxt   = IDLE;
                    mem_done_o  = 1'b1;
                    mem_err_o   = tout_evt;
                    mem_rdata_o = ready_evt ? bus.bus_rdata_i : '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.bus_req_o  = busy;
    assign stallreq_if_o  = if_req_i & ~if_done_o;
    assign stallreq_mem_o = mem_req_i & ~mem_done_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_wdata_o <= '0;
            bus.bus_wstrb_o <= '0;
        end else if (grant_mem) begin
            bus.bus_we_o    <= mem_we_i;
            bus.bus_addr_o  <= mem_addr_i;
            bus.bus_wdata_o <= mem_wdata_i;
            bus.bus_wstrb_o <= mem_wstrb_i;
        end else if (grant_if) begin
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= if_addr_i;
            bus.bus_wdata_o <= '0;
            bus.bus_wstrb_o <= '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               tcnt <= '0;
        else if (grant_mem || grant_if)        tcnt <= '0;
        else if (busy && !bus.bus_ready_i)     tcnt <= tcnt + 1'b1;
    end

    // Counts MEM grants that jumped ahead of a waiting IF request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_mem) begin
            if (!if_elig)                streak <= '0;
            else if (streak != STRK_MAX) streak <= streak + 1'b1;
        end else if (grant_if) begin
            streak <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 discard <= 1'b0;
        else if (busy && state_nxt == IDLE)      discard <= 1'b0;
        else if (state == BUSY_IF && if_flush_i) discard <= 1'b1;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } cmd_t;

    typedef struct packed {
        logic          is_if;
        logic [31:0]   rdata;
        logic          err;
    } done_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, if_flush_i;
    logic [AW-1:0] if_addr_i;
    logic          if_done_o, if_err_o;
    logic [DW-1:0] if_rdata_o;
    logic          mem_req_i, mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [3:0]    mem_wstrb_i;
    logic          mem_done_o, mem_err_o;
    logic [DW-1:0] mem_rdata_o;
    logic          stallreq_if_o, stallreq_mem_o;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BURST_MAX(4), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .bus(bus),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    always #5 clk = ~clk;

    cmd_t  cmd_q[$];
    done_t done_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic  prev_req = 1'b0;
    cmd_t  mc;
    done_t md;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.bus_req_o && !prev_req) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    mc = cmd_q.pop_front();
                    check("bus_we", bus.bus_we_o, mc.we);
                    check("bus_addr", bus.bus_addr_o, mc.addr);
                    check("bus_wstrb", bus.bus_wstrb_o, mc.wstrb);
                    if (mc.we) check("bus_wdata", bus.bus_wdata_o, mc.wdata);
                end
            end
            prev_req = bus.bus_req_o;
            if (if_done_o || mem_done_o) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {if_done_o, mem_done_o}, 0);
                end else begin
                    md = done_q.pop_front();
                    check("done_owner", {if_done_o, mem_done_o}, md.is_if ? 2'b10 : 2'b01);
                    check("done_rdata", md.is_if ? if_rdata_o : mem_rdata_o, md.rdata);
                    check("done_err", md.is_if ? if_err_o : mem_err_o, md.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int lat, input logic [31:0] rd);
        int n = 0;
        while (!bus.bus_req_o && n < 20) begin
            cyc();
            n++;
        end
        if (!bus.bus_req_o) check("serve_wait", 0, 1);
        repeat (lat) cyc();
        bus.bus_rdata_i = rd;
        bus.bus_ready_i = 1'b1;
        cyc();
        bus.bus_ready_i = 1'b0;
        bus.bus_rdata_i = '0;
    endtask

    function automatic cmd_t mk_cmd(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = wd; c.wstrb = st;
        return c;
    endfunction

    function automatic done_t mk_done(input logic is_if, input logic [31:0] rd, input logic err);
        done_t d;
        d.is_if = is_if; d.rdata = rd; d.err = err;
        return d;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int n;
        rst = 1'b1;
        if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        bus.bus_ready_i = 1'b0; bus.bus_rdata_i = '0;
        #2;
        check("rst_bus_req", bus.bus_req_o, 0);
        check("rst_bus_addr", bus.bus_addr_o, 0);
        check("rst_bus_wstrb", bus.bus_wstrb_o, 0);
        check("rst_dones", {if_done_o, mem_done_o, if_err_o, mem_err_o}, 0);
        check("rst_stalls", {stallreq_if_o, stallreq_mem_o}, 0);
        repeat (2) cyc();
        rst = 1'b0;

        // Single IF read: request cycle 1, ready cycle 4
        cyc();
        if_req_i = 1; if_addr_i = 32'h100;
        cmd_q.push_back(mk_cmd(0, 32'h100, 0, 4'hF));
        done_q.push_back(mk_done(1, 32'hDEADBEEF, 0));
        #2;
        check("if1_stall_c1", stallreq_if_o, 1);
        check("if1_req_c1", bus.bus_req_o, 0);
        cyc();
        check("if1_req_c2", bus.bus_req_o, 1);
        cyc();
        check("if1_stall_c3", stallreq_if_o, 1);
        cyc();
        bus.bus_ready_i = 1; bus.bus_rdata_i = 32'hDEADBEEF;
        #2;
        check("if1_done_c4", if_done_o, 1);
        check("if1_stall_c4", stallreq_if_o, 0);
        check("if1_memdone_c4", mem_done_o, 0);
        cyc();
        bus.bus_ready_i = 0; bus.bus_rdata_i = '0; if_req_i = 0;
        #2;
        check("if1_req_c5", bus.bus_req_o, 0);

        // MEM write vs IF contention
        cyc();
        if_req_i = 1; if_addr_i = 32'h140;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h200; mem_wdata_i = 32'h12345678; mem_wstrb_i = 4'h3;
        cmd_q.push_back(mk_cmd(1, 32'h200, 32'h12345678, 4'h3));
        cmd_q.push_back(mk_cmd(0, 32'h140, 0, 4'hF));
        done_q.push_back(mk_done(0, 32'h0000AAAA, 0));
        done_q.push_back(mk_done(1, 32'h11110000, 0));
        serve(1, 32'h0000AAAA);
        mem_req_i = 0; mem_we_i = 0;
        #2;
        check("cont_bubble", bus.bus_req_o, 0);
        cyc();
        check("cont_if_req", bus.bus_req_o, 1);
        serve(0, 32'h11110000);
        if_req_i = 0;

        // Starvation: four MEM grants, then IF forced in
        cyc();
        if_req_i = 1; if_addr_i = 32'h700;
        mem_req_i = 1; mem_we_i = 0; mem_wstrb_i = 4'h0; mem_addr_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            cmd_q.push_back(mk_cmd(0, 32'h300 + 4 * i, 0, 4'h0));
            done_q.push_back(mk_done(0, 32'h1000 + i, 0));
        end
        cmd_q.push_back(mk_cmd(0, 32'h700, 0, 4'hF));
        done_q.push_back(mk_done(1, 32'h2000, 0));
        cmd_q.push_back(mk_cmd(0, 32'h310, 0, 4'h0));
        done_q.push_back(mk_done(0, 32'h3000, 0));
        cmd_q.push_back(mk_cmd(0, 32'h740, 0, 4'hF));
        done_q.push_back(mk_done(1, 32'h4000, 0));
        for (int i = 0; i < 4; i++) begin
            serve(0, 32'h1000 + i);
            mem_addr_i = 32'h300 + 4 * (i + 1);
        end
        serve(0, 32'h2000);
        if_addr_i = 32'h740;
        serve(0, 32'h3000);
        mem_req_i = 0;
        serve(0, 32'h4000);
        if_req_i = 0;

        // Timeout on a MEM read that never sees ready
        cyc();
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h800;
        bus.bus_rdata_i = 32'h0BADBAD0;
        cmd_q.push_back(mk_cmd(0, 32'h800, 0, 4'h0));
        done_q.push_back(mk_done(0, 32'h0, 1));
        busy_cnt = 0;
        n = 0;
        while (!mem_done_o && n < 400) begin
            cyc();
            if (n == 5) mem_addr_i = 32'h900;
            #2;
            if (bus.bus_req_o) busy_cnt++;
            if (n == 10) check("to_addr_held", bus.bus_addr_o, 32'h800);
            n++;
        end
        check("to_busy_cycles", busy_cnt, 255);
        check("to_err", mem_err_o, 1);
        check("to_rdata", mem_rdata_o, 0);
        cyc();
        mem_req_i = 0;
        #2;
        check("to_req_after", bus.bus_req_o, 0);
        cyc();
        bus.bus_ready_i = 1; bus.bus_rdata_i = 32'h55;
        #2;
        check("late_ready_done", {if_done_o, mem_done_o}, 0);
        cyc();
        bus.bus_ready_i = 0; bus.bus_rdata_i = '0;

        // Flush while IF is in flight
        cyc();
        if_req_i = 1; if_addr_i = 32'h500;
        cmd_q.push_back(mk_cmd(0, 32'h500, 0, 4'hF));
        cyc();
        cyc();
        if_flush_i = 1; if_addr_i = 32'h600;
        cyc();
        if_flush_i = 0;
        cyc();
        bus.bus_ready_i = 1; bus.bus_rdata_i = 32'h77;
        #2;
        check("flush_no_done", if_done_o, 0);
        check("flush_stall", stallreq_if_o, 1);
        cmd_q.push_back(mk_cmd(0, 32'h600, 0, 4'hF));
        done_q.push_back(mk_done(1, 32'h88, 0));
        cyc();
        bus.bus_ready_i = 0; bus.bus_rdata_i = '0;
        #2;
        check("flush_idle_req", bus.bus_req_o, 0);
        cyc();
        check("flush_regrant", bus.bus_req_o, 1);
        serve(0, 32'h88);
        if_req_i = 0;

        // Asynchronous reset in the middle of a MEM write
        cyc();
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'hA00; mem_wdata_i = 32'hCAFE; mem_wstrb_i = 4'hF;
        cmd_q.push_back(mk_cmd(1, 32'hA00, 32'hCAFE, 4'hF));
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        mem_req_i = 0;
        #1;
        check("arst_bus_req", bus.bus_req_o, 0);
        check("arst_bus_cmd", {bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o}, 0);
        check("arst_done", {mem_done_o, mem_err_o, stallreq_mem_o}, 0);
        cyc();
        rst = 1'b0;
        cyc();
        bus.bus_ready_i = 1; bus.bus_rdata_i = 32'h99;
        #2;
        check("arst_after_done", {if_done_o, mem_done_o}, 0);
        cyc();
        bus.bus_ready_i = 0; bus.bus_rdata_i = '0;
        repeat (3) cyc();

        check("cmd_q_left", cmd_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
